// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// Both channels: a transfer happens on a rising clk edge where valid and ready are both 1.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic             borrow_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, borrow_in, out_ready,
        input  in_ready, out_valid, c, borrow_out, overflow
    );

    modport slave (
        input  in_valid, a, b, borrow_in, out_ready,
        output in_ready, out_valid, c, borrow_out, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: c = a - b - borrow_in, one bit per clock, LSB first.
// Results are held in DONE until the consumer accepts them.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    serial_subtractor_if.slave bus,
    output logic [1:0]         dbg_state
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] c_q;
    logic [CW-1:0]    cnt_q;
    logic             brw_q;
    logic             borrow_out_q;
    logic             overflow_q;

    logic a_bit;
    logic b_bit;
    logic d_bit;
    logic brw_next;
    logic last_bit;

    always_comb begin
        a_bit    = a_q[cnt_q];
        b_bit    = b_q[cnt_q];
        d_bit    = a_bit ^ b_bit ^ brw_q;
        brw_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & brw_q);
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_d = BUSY;
            end
            BUSY: begin
                if (last_bit) state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                // Handshake always returns to IDLE; a new operand waits a cycle.
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            cnt_q        <= '0;
            brw_q        <= 1'b0;
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        brw_q <= bus.borrow_in;
                        cnt_q <= '0;
                    end
                end
                BUSY: begin
                    c_q   <= {d_bit, c_q[WIDTH-1:1]};
                    brw_q <= brw_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_bit) begin
                        borrow_out_q <= brw_next;
                        // d_bit is the final MSB of c on this edge.
                        overflow_q   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_bit != a_q[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.c          = c_q;
    assign bus.borrow_out = borrow_out_q;
    assign bus.overflow   = overflow_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk;
  logic reset;
  logic [1:0] dbg_state;
  int checks;
  int failures;
  logic [W+1:0] exp_q[$];

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W:0] diff;
    logic ovf;
    diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
    return {diff[W], ovf, diff[W-1:0]};
  endfunction

  function automatic logic [W+1:0] result();
    return {bus.borrow_out, bus.overflow, bus.c};
  endfunction

  // driver: one full operation with optional output stall and input disturbance
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input int stall, input bit disturb);
    int cycles;
    logic [W+1:0] exp;
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.a = a;
    bus.b = b;
    bus.borrow_in = bin;
    bus.in_valid = 1'b1;
    exp_q.push_back(model(a, b, bin));
    tick();
    bus.in_valid = 1'b0;
    check("state_busy", 32'(dbg_state), 32'd1);
    cycles = 0;
    while (!bus.out_valid && cycles < 40) begin
      if (disturb && cycles < 3) begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        bus.borrow_in = ~bin;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      cycles++;
    end
    bus.in_valid = 1'b0;
    check("latency", 32'(cycles), 32'(W));
    exp = exp_q.pop_front();
    if (!bus.out_valid) return;
    for (int i = 0; i < stall; i++) begin
      check("stall_result", 32'(result()), 32'(exp));
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    check("result", 32'(result()), 32'(exp));
    check("state_done", 32'(dbg_state), 32'd2);
    bus.out_ready = 1'b1;
    if (disturb) bus.in_valid = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    check("state_idle_after", 32'(dbg_state), 32'd0);
    check("out_valid_drop", 32'(bus.out_valid), 32'd0);
    check("in_ready_after", 32'(bus.in_ready), 32'd1);
    check("result_held", 32'(result()), 32'(exp));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.borrow_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(result()), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // basic and boundary vectors
    do_op(8'h05, 8'h03, 1'b0, 0, 1'b0);
    do_op(8'h03, 8'h05, 1'b0, 0, 1'b0);
    do_op(8'h00, 8'h00, 1'b1, 1, 1'b0);
    do_op(8'h80, 8'h01, 1'b0, 0, 1'b0);
    do_op(8'h7F, 8'hFF, 1'b0, 2, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    // held output
    do_op(8'hA5, 8'h3C, 1'b1, 5, 1'b0);
    // ignored in_valid / operand changes while busy, and in_valid at DONE handshake
    do_op(8'h12, 8'h34, 1'b0, 1, 1'b1);

    // reset four cycles into BUSY
    bus.a = 8'h55;
    bus.b = 8'h22;
    bus.borrow_in = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    check("pre_rst_busy", 32'(dbg_state), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_state", 32'(dbg_state), 32'd0);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_result", 32'(result()), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    tick();
    do_op(8'h40, 8'h41, 1'b1, 0, 1'b0);

    // random operations
    for (int n = 0; n < 100; n++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
